// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared widths and FSM state encoding for the data memory responder
package data_mem_responder_pkg;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 10;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ACCESS = 2'd1;
    localparam logic [1:0] STATE_RESP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = STATE_IDLE,
        ST_ACCESS = STATE_ACCESS,
        ST_RESP   = STATE_RESP
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - LD/ST request and response handshake bundle
interface data_mem_responder_if #(
    parameter int DATA_W = data_mem_responder_pkg::DATA_W,
    parameter int ADDR_W = data_mem_responder_pkg::ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_is_write;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_is_write
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_is_write
    );

endinterface

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage with one synchronous write port and one registered read port
module mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents deliberately survive reset.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency LD/ST responder: IDLE -> ACCESS x LATENCY -> RESP
module data_mem_responder #(
    parameter int DATA_W  = data_mem_responder_pkg::DATA_W,
    parameter int ADDR_W  = data_mem_responder_pkg::ADDR_W,
    parameter int DEPTH   = 1 << ADDR_W,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    import data_mem_responder_pkg::*;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_is_write_q;
    logic              commit;
    logic [DATA_W-1:0] mem_rdata;

    // Reset on the same edge as the last ACCESS cycle must suppress the write.
    assign commit = (state == ST_ACCESS) && (cnt == 4'd0) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= 4'd0;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_is_write_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        state       <= ST_ACCESS;
                        cnt         <= CNT_LOAD;
                        req_ready_q <= 1'b0;
                        we_q        <= bus.req_we;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        state          <= ST_RESP;
                        rsp_valid_q    <= 1'b1;
                        rsp_is_write_q <= we_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    // req_ready stays low here, so a request on the handshake edge waits for IDLE.
                    if (bus.rsp_ready) begin
                        state          <= ST_IDLE;
                        rsp_valid_q    <= 1'b0;
                        rsp_is_write_q <= 1'b0;
                        req_ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (commit && we_q),
        .waddr (addr_q),
        .wdata (wdata_q),
        .re    (commit && !we_q),
        .raddr (addr_q),
        .rdata (mem_rdata)
    );

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_is_write = rsp_is_write_q;
    assign bus.rsp_rdata    = (rsp_valid_q && !rsp_is_write_q) ? mem_rdata : '0;

endmodule
